// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
// Watches an hsync/vsync pair sampled on p_tick. It measures line and frame
// timing, rebuilds x/y pixel coordinates, and declares lock after a run of
// consecutive good frames. While locked, any timing violation pulses err and
// bumps a saturating error counter.
module vga_sync_monitor #(
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC       = 96,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC       = 2,
    parameter int V_SYNC_START = 513,
    parameter int LOCK_FRAMES  = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       hsync,
    input  logic       vsync,
    output logic       locked,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [9:0] h_period,
    output logic [9:0] v_period,
    output logic       frame_start,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam logic [9:0] CNT_MAX    = 10'd1023;
    localparam logic [9:0] H_TOTAL_L  = 10'(H_TOTAL);
    localparam logic [9:0] H_SYNC_L   = 10'(H_SYNC);
    localparam logic [9:0] H_START_L  = 10'(H_SYNC_START);
    localparam logic [9:0] H_LAST_L   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_TOTAL_L  = 10'(V_TOTAL);
    localparam logic [9:0] V_SYNC_L   = 10'(V_SYNC);
    localparam logic [9:0] V_START_L  = 10'(V_SYNC_START);
    localparam logic [9:0] V_LAST_L   = 10'(V_TOTAL - 1);

    // The line-length counter saturates at 1023, which is below the
    // 2*H_TOTAL loss-of-hsync limit, so the watchdog needs its own counter.
    localparam int             WD_W     = $clog2(2 * H_TOTAL + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(2 * H_TOTAL - 1);
    localparam logic [WD_W-1:0] WD_SAT   = WD_W'(2 * H_TOTAL);

    localparam int              GC_W    = $clog2(LOCK_FRAMES + 1);
    localparam logic [GC_W-1:0] GC_LOCK = GC_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t          state, state_nxt;
    logic            hs_q, vs_q;
    logic [9:0]      h_cnt, hw_cnt, h_width;
    logic [9:0]      l_cnt, vw_cnt, v_width;
    logic [WD_W-1:0] wd_cnt;
    logic [GC_W-1:0] gcnt;
    logic            frame_ok;

    logic            h_rise, h_fall, v_rise, v_fall;
    logic [9:0]      h_inc, hw_inc, l_inc, vw_inc, v_new;
    logic [GC_W-1:0] gc_inc;
    logic            line_bad, frame_good, timeout, x_wrap;
    logic            err_nxt, locked_nxt;

    // Previous-tick sync samples, used for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else if (p_tick) begin
            hs_q <= hsync;
            vs_q <= vsync;
        end
    end

    // Edge strobes are qualified by p_tick so non-tick cycles cannot act
    assign h_rise = p_tick &  hsync & ~hs_q;
    assign h_fall = p_tick & ~hsync &  hs_q;
    assign v_rise = p_tick &  vsync & ~vs_q;
    assign v_fall = p_tick & ~vsync &  vs_q;

    assign h_inc  = (h_cnt  == CNT_MAX) ? CNT_MAX : h_cnt  + 10'd1;
    assign hw_inc = (hw_cnt == CNT_MAX) ? CNT_MAX : hw_cnt + 10'd1;
    assign l_inc  = (l_cnt  == CNT_MAX) ? CNT_MAX : l_cnt  + 10'd1;
    assign vw_inc = (vw_cnt == CNT_MAX) ? CNT_MAX : vw_cnt + 10'd1;
    assign gc_inc = (gcnt == GC_LOCK) ? GC_LOCK : gcnt + GC_W'(1);

    // An hsync edge arriving together with a vsync edge closes the old frame
    assign v_new = h_rise ? l_inc : l_cnt;

    // The line ending on this hsync edge is judged first; the frame verdict on
    // a coincident vsync edge then already includes it.
    assign line_bad   = h_rise & ((h_inc != H_TOTAL_L) | (h_width != H_SYNC_L));
    assign frame_good = frame_ok & ~line_bad & (v_new == V_TOTAL_L) &
                        (v_width == V_SYNC_L);
    assign timeout    = p_tick & ~h_rise & (wd_cnt == WD_LIMIT);
    assign x_wrap     = ~h_rise & (x == H_LAST_L);

    // Horizontal measurement: line length, hsync width, loss-of-hsync watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt    <= '0;
            h_period <= '0;
            hw_cnt   <= '0;
            h_width  <= '0;
            wd_cnt   <= '0;
        end else if (p_tick) begin
            if (h_rise) begin
                h_period <= h_inc;
                h_cnt    <= '0;
                wd_cnt   <= '0;
            end else begin
                h_cnt <= h_inc;
                if (wd_cnt != WD_SAT)
                    wd_cnt <= wd_cnt + WD_W'(1);
            end
            // Width counts the rising tick itself, so a 1-tick pulse reads 1
            if (h_rise)
                hw_cnt <= 10'd1;
            else if (hsync)
                hw_cnt <= hw_inc;
            if (h_fall)
                h_width <= hw_cnt;
        end
    end

    // Vertical measurement: lines per frame and vsync width in hsync edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_cnt    <= '0;
            v_period <= '0;
            vw_cnt   <= '0;
            v_width  <= '0;
        end else if (p_tick) begin
            if (v_rise) begin
                v_period <= v_new;
                l_cnt    <= '0;
            end else if (h_rise) begin
                l_cnt <= l_inc;
            end
            if (v_rise)
                vw_cnt <= h_rise ? 10'd1 : 10'd0;
            else if (vsync && h_rise)
                vw_cnt <= vw_inc;
            if (v_fall)
                v_width <= vw_cnt;
        end
    end

    // Per-frame "all lines good" flag, re-armed at each vsync edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_ok <= 1'b0;
        else if (v_rise)
            frame_ok <= 1'b1;
        else if (line_bad)
            frame_ok <= 1'b0;
    end

    // Recovered pixel coordinates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (p_tick) begin
            if (h_rise)
                x <= H_START_L;
            else if (x_wrap)
                x <= '0;
            else
                x <= x + 10'd1;
            if (v_rise)
                y <= V_START_L;
            else if (x_wrap)
                y <= (y == V_LAST_L) ? 10'd0 : y + 10'd1;
        end
    end

    // Good-frame run length; any break in the run restarts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt <= '0;
        end else if (timeout) begin
            gcnt <= '0;
        end else begin
            case (state)
                SEARCH: if (v_rise) gcnt <= '0;
                CHECK:  if (v_rise) gcnt <= frame_good ? gc_inc : '0;
                LOCKED: if (line_bad || (v_rise && !frame_good)) gcnt <= '0;
                default: gcnt <= '0;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= SEARCH;
        else
            state <= state_nxt;
    end

    // FSM next state; the watchdog overrides everything
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = SEARCH;
        end else begin
            case (state)
                SEARCH: if (v_rise) state_nxt = CHECK;
                CHECK:  if (v_rise && frame_good && (gc_inc == GC_LOCK))
                            state_nxt = LOCKED;
                LOCKED: if (line_bad || (v_rise && !frame_good))
                            state_nxt = CHECK;
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // FSM outputs; violations only count as errors while locked
    always_comb begin
        locked_nxt = (state_nxt == LOCKED);
        err_nxt    = (state == LOCKED) &
                     (timeout | line_bad | (v_rise & ~frame_good));
    end

    // Registered status outputs and saturating error counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked      <= 1'b0;
            err         <= 1'b0;
            frame_start <= 1'b0;
            err_cnt     <= '0;
        end else begin
            locked      <= locked_nxt;
            err         <= err_nxt;
            frame_start <= v_rise;
            if (err_nxt && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800: expected ticks per line.
REQ-002 SHALL have parameter H_SYNC, default 96: expected hsync high width, ticks.
REQ-003 SHALL have parameter H_SYNC_START, default 656: x value at the hsync rising-edge tick.
REQ-004 SHALL have parameter V_TOTAL, default 525: expected lines per frame.
REQ-005 SHALL have parameter V_SYNC, default 2: expected vsync high width, lines.
REQ-006 SHALL have parameter V_SYNC_START, default 513: y value at the vsync rising-edge tick.
REQ-007 SHALL have parameter LOCK_FRAMES, default 2: consecutive good frames required to lock.
REQ-008 clk  input  1  system clock.
REQ-009 reset  input  1  asynchronous, active-high.
REQ-010 p_tick  input  1  pixel-rate enable; all sampling and counting occurs only on p_tick cycles.
REQ-011 hsync, vsync  input  1 each  active-high sync under test.
REQ-012 locked  output  1  timing is locked.
REQ-013 x, y  output  10 each  recovered pixel coordinates.
REQ-014 h_period, v_period  output  10 each  last measured line length (ticks) and frame length (lines).
REQ-015 frame_start  output  1  one-clk pulse on the vsync rising-edge tick.
REQ-016 err  output  1  one-clk pulse on any timing violation while locked.
REQ-017 err_cnt  output  8  violation count, saturating at 255.

Function
REQ-018 Edge detection SHALL compare the current sample against the previous p_tick sample; a rising edge = current 1 and previous 0.
REQ-019 Tick counter SHALL count ticks since the last hsync rising edge, saturating at 1023; on an edge, h_period <= count+1 (clamped to 1023), then count restarts.
REQ-020 Pulse widths SHALL be measured as ticks (hsync) or hsync edges (vsync) spent high, captured on the falling edge.
REQ-021 A line SHALL be good iff h_period == H_TOTAL and the hsync width == H_SYNC.
REQ-022 Line counter SHALL count hsync rising edges between vsync rising edges; on a vsync edge, v_period <= count (clamped to 1023).
REQ-023 A frame SHALL be good iff every line in it is good, v_period == V_TOTAL, and the vsync width == V_SYNC.
REQ-024 On each tick, x SHALL load H_SYNC_START on an hsync edge, wrap from H_TOTAL-1 to 0, and otherwise increment.
REQ-025 y SHALL increment on each x wrap, wrap from V_TOTAL-1 to 0, and load V_SYNC_START on a vsync edge; the load has priority over the increment.
REQ-026 The FSM SHALL have states SEARCH, CHECK, and LOCKED.
REQ-027 SEARCH -> CHECK on the first vsync edge; the good-frame count is cleared.
REQ-028 In CHECK, each vsync edge SHALL increment the good-frame count on a good frame and clear it on a bad frame; reaching LOCK_FRAMES SHALL go to LOCKED.
REQ-029 In LOCKED, a bad line or bad frame SHALL pulse err, increment err_cnt, clear the good-frame count, and go to CHECK in the same cycle.
REQ-030 From any state, if the tick counter reaches 2*H_TOTAL without an hsync edge, the FSM SHALL go to SEARCH; an err pulse occurs only if the FSM was LOCKED.
REQ-031 locked SHALL be 1 only in LOCKED and SHALL be registered.
REQ-032 A vsync edge SHALL be evaluated after the line check of the same tick, so a bad last line fails that frame.
REQ-033 Non-p_tick cycles SHALL hold all state; err and frame_start are 0 on them.

Reset
REQ-034 Reset SHALL take effect immediately at any time, including mid-frame.
REQ-035 On reset, state SHALL be SEARCH, all counters and outputs 0, and the previous sync samples 0.

Verification
REQ-036 Nominal 800x525 stream, p_tick every 2nd clk, from reset -> locked rises on the 3rd vsync edge (SEARCH->CHECK, then 2 good frames); h_period=800, v_period=525, err_cnt=0.
REQ-037 Locked; one line stretched to 801 ticks -> err pulses once, err_cnt=1, locked=0; lock regained after 2 further good frames.
REQ-038 Locked; hsync held low for 1600 ticks -> state SEARCH, locked=0, err_cnt=1; resumed stream relocks after 3 vsync edges.
REQ-039 Alignment check -> at the hsync edge tick, x=656; at the vsync edge tick, y=513 and frame_start=1 for exactly one clk; x wraps 799->0 with y incrementing.
REQ-040 Edge cases: vsync width 3 lines -> frame bad, no lock; err_cnt pre-driven to 255 with further violations -> stays 255; reset asserted mid-frame -> all outputs 0 next cycle.
